// File: rtl/mining_job_scheduler.sv
// Mining job scheduler: accepts parsed command packets, runs the SHA-256d core over a
// nonce range and reports the first nonce whose digest meets the leading-zero target.
module mining_job_scheduler #(
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned TAIL_W  = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_ready,
    input  logic [7:0]         cmd_code,
    input  logic [255:0]       cmd_payload,
    output logic               data_request,
    output logic               core_start,
    output logic [255:0]       core_midstate,
    output logic [TAIL_W-1:0]  core_tail,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [255:0]       core_hash,
    output logic               result_valid,
    input  logic               result_ack,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [2:0]         status
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StReport} state_e;

    localparam logic [2:0] StatIdle      = 3'd0;
    localparam logic [2:0] StatRunning   = 3'd1;
    localparam logic [2:0] StatFound     = 3'd2;
    localparam logic [2:0] StatExhausted = 3'd3;
    localparam logic [2:0] StatAborted   = 3'd4;
    localparam logic [2:0] StatBadCmd    = 3'd5;

    localparam logic [7:0] CmdNop      = 8'd0;
    localparam logic [7:0] CmdLoadMid  = 8'd1;
    localparam logic [7:0] CmdLoadTail = 8'd2;
    localparam logic [7:0] CmdStart    = 8'd3;
    localparam logic [7:0] CmdAbort    = 8'd4;

    state_e               state_q, state_d;
    logic                 armed_q, armed_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 data_request_q, data_request_d;
    logic                 core_start_q, core_start_d;
    logic [255:0]         midstate_q, midstate_d;
    logic [TAIL_W-1:0]    tail_q, tail_d;
    logic [7:0]           target_q, target_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [NONCE_W-1:0]   remaining_q, remaining_d;
    logic [255:0]         hash_q, hash_d;
    logic                 result_valid_q, result_valid_d;
    logic [NONCE_W-1:0]   result_nonce_q, result_nonce_d;
    logic [2:0]           status_q, status_d;

    logic                 allowed;
    logic                 accept;
    logic [255:0]         top_mask;
    logic                 match;
    logic [NONCE_W-1:0]   pl_nonce;
    logic [NONCE_W-1:0]   pl_count;

    assign pl_nonce = cmd_payload[NONCE_W-1:0];
    assign pl_count = cmd_payload[2*NONCE_W+7:NONCE_W+8];

    // Target selects how many digest MSBs must be zero; target 0 yields an empty mask.
    assign top_mask = ~({256{1'b1}} >> target_q);
    assign match    = ((hash_q & top_mask) == '0);

    // Which command codes the current state is willing to consume.
    always_comb begin
        allowed = 1'b0;
        unique case (state_q)
            StIdle:          allowed = 1'b1;
            StIssue, StWait: allowed = (cmd_code == CmdAbort);
            StReport:        allowed = (cmd_code != CmdStart) && (cmd_code != CmdAbort);
            default:         allowed = 1'b0;
        endcase
    end

    assign accept = cmd_ready && armed_q && allowed;

    // Next-state logic: command effects first, then per-state sequencing.
    always_comb begin
        state_d        = state_q;
        abort_pend_d   = abort_pend_q;
        midstate_d     = midstate_q;
        tail_d         = tail_q;
        target_d       = target_q;
        nonce_d        = nonce_q;
        remaining_d    = remaining_q;
        hash_d         = hash_q;
        result_valid_d = result_valid_q;
        result_nonce_d = result_nonce_q;
        status_d       = status_q;
        data_request_d = accept;
        // Re-arm only once the parser has dropped ready, so one packet is taken once.
        if (accept) begin
            armed_d = 1'b0;
        end else if (!cmd_ready) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        if (accept) begin
            case (cmd_code)
                CmdNop:      ;
                CmdLoadMid:  midstate_d = cmd_payload;
                CmdLoadTail: tail_d = cmd_payload[TAIL_W-1:0];
                CmdStart: begin
                    nonce_d      = pl_nonce;
                    target_d     = cmd_payload[NONCE_W+7:NONCE_W];
                    remaining_d  = pl_count;
                    abort_pend_d = 1'b0;
                    if (pl_count == '0) begin
                        status_d       = StatExhausted;
                        result_nonce_d = pl_nonce;
                        result_valid_d = 1'b1;
                        state_d        = StReport;
                    end else begin
                        status_d = StatRunning;
                        state_d  = StIssue;
                    end
                end
                CmdAbort: begin
                    if (state_q == StIdle) begin
                        status_d = StatAborted;
                    end else begin
                        abort_pend_d = 1'b1;
                    end
                end
                default:     status_d = StatBadCmd;
            endcase
        end

        unique case (state_q)
            StIdle: ;
            StIssue: state_d = StWait;
            StWait: begin
                if (core_done) begin
                    hash_d  = core_hash;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (abort_pend_q) begin
                    abort_pend_d   = 1'b0;
                    status_d       = StatAborted;
                    result_nonce_d = nonce_q;
                    result_valid_d = 1'b1;
                    state_d        = StReport;
                end else if (match) begin
                    status_d       = StatFound;
                    result_nonce_d = nonce_q;
                    result_valid_d = 1'b1;
                    state_d        = StReport;
                end else if (remaining_q == NONCE_W'(1)) begin
                    status_d       = StatExhausted;
                    result_nonce_d = nonce_q;
                    result_valid_d = 1'b1;
                    state_d        = StReport;
                end else begin
                    nonce_d     = nonce_q + NONCE_W'(1);
                    remaining_d = remaining_q - NONCE_W'(1);
                    state_d     = StIssue;
                end
            end
            StReport: begin
                if (result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // core_start is high for exactly the cycle spent in StIssue.
        core_start_d = (state_d == StIssue);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            armed_q        <= 1'b1;
            abort_pend_q   <= 1'b0;
            data_request_q <= 1'b0;
            core_start_q   <= 1'b0;
            midstate_q     <= '0;
            tail_q         <= '0;
            target_q       <= '0;
            nonce_q        <= '0;
            remaining_q    <= '0;
            hash_q         <= '0;
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            status_q       <= StatIdle;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            abort_pend_q   <= abort_pend_d;
            data_request_q <= data_request_d;
            core_start_q   <= core_start_d;
            midstate_q     <= midstate_d;
            tail_q         <= tail_d;
            target_q       <= target_d;
            nonce_q        <= nonce_d;
            remaining_q    <= remaining_d;
            hash_q         <= hash_d;
            result_valid_q <= result_valid_d;
            result_nonce_q <= result_nonce_d;
            status_q       <= status_d;
        end
    end

    assign data_request  = data_request_q;
    assign core_start    = core_start_q;
    assign core_midstate = midstate_q;
    assign core_tail     = tail_q;
    assign core_nonce    = nonce_q;
    assign result_valid  = result_valid_q;
    assign result_nonce  = result_nonce_q;
    assign status        = status_q;

endmodule

// File: tb/tb_mining_job_scheduler.sv
// Self-checking bench for mining_job_scheduler with a behavioural hash-core responder
// and a job-level reference model.
module tb_mining_job_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_ready;
    logic [7:0]   cmd_code;
    logic [255:0] cmd_payload;
    logic         data_request;
    logic         core_start;
    logic [255:0] core_midstate;
    logic [95:0]  core_tail;
    logic [31:0]  core_nonce;
    logic         core_done;
    logic [255:0] core_hash;
    logic         result_valid;
    logic         result_ack;
    logic [31:0]  result_nonce;
    logic [2:0]   status;

    always #5 clk = ~clk;

    mining_job_scheduler #(.NONCE_W(32), .TAIL_W(96)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_ready     (cmd_ready),
        .cmd_code      (cmd_code),
        .cmd_payload   (cmd_payload),
        .data_request  (data_request),
        .core_start    (core_start),
        .core_midstate (core_midstate),
        .core_tail     (core_tail),
        .core_nonce    (core_nonce),
        .core_done     (core_done),
        .core_hash     (core_hash),
        .result_valid  (result_valid),
        .result_ack    (result_ack),
        .result_nonce  (result_nonce),
        .status        (status)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit           core_auto = 1'b0;
    int           lat_lo = 1;
    int           lat_hi = 4;
    logic [255:0] digests[$];
    logic [255:0] plan[$];
    logic [31:0]  started[$];
    logic [31:0]  exp_nonces[$];
    logic [2:0]   exp_status;
    logic [31:0]  exp_rnonce;

    // Behavioural hash core: returns queued digests after a random latency.
    initial begin
        int lat;
        core_done = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            if (core_auto && core_start) begin
                started.push_back(core_nonce);
                lat = int'($urandom_range(lat_hi, lat_lo));
                repeat (lat) @(negedge clk);
                core_hash = (digests.size() > 0) ? digests.pop_front() : {256{1'b1}};
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int lz(input logic [255:0] d);
        int n = 0;
        for (int i = 255; i >= 0; i--) begin
            if (d[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Job-level model: walk the nonce range, stop at the first digest with enough zeros.
    task automatic model_job(input logic [31:0] n0, input int tgt, input logic [31:0] cnt);
        logic [31:0]  n;
        logic [255:0] d;
        exp_nonces.delete();
        exp_status = 3'd3;
        exp_rnonce = n0;
        for (int i = 0; i < int'(cnt); i++) begin
            n = n0 + 32'(i);
            exp_nonces.push_back(n);
            exp_rnonce = n;
            d = (i < plan.size()) ? plan[i] : {256{1'b1}};
            if (lz(d) >= tgt) begin
                exp_status = 3'd2;
                break;
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] code, input logic [255:0] pl,
                            output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        cmd_code = code;
        cmd_payload = pl;
        cmd_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (data_request) begin
                ok = 1'b1;
                waited = i;
                break;
            end
        end
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_result(input string name);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack_clear: got %b required 0", name, result_valid);
        end
        n_tests++;
        if (status !== exp_status) begin
            n_fail++;
            $display("FAIL %s status_hold: got %0d required %0d", name, status, exp_status);
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] n0, input logic [7:0] tgt,
                           input logic [31:0] cnt);
        bit ok;
        int w;
        model_job(n0, int'(tgt), cnt);
        digests = plan;
        started.delete();
        send_cmd(8'd3, {184'b0, cnt, tgt, n0}, ok, w);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s start_ack: got 0 required 1", name);
        end
        wait_result(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s result_timeout: got 0 required 1", name);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (status !== exp_status) begin
            n_fail++;
            $display("FAIL %s status: got %0d required %0d", name, status, exp_status);
        end
        n_tests++;
        if (result_nonce !== exp_rnonce) begin
            n_fail++;
            $display("FAIL %s result_nonce: got %h required %h", name, result_nonce, exp_rnonce);
        end
        n_tests++;
        if (started.size() != exp_nonces.size()) begin
            n_fail++;
            $display("FAIL %s start_count: got %0d required %0d", name, started.size(),
                     exp_nonces.size());
        end
        for (int i = 0; i < started.size() && i < exp_nonces.size(); i++) begin
            n_tests++;
            if (started[i] !== exp_nonces[i]) begin
                n_fail++;
                $display("FAIL %s nonce[%0d]: got %h required %h", name, i, started[i],
                         exp_nonces[i]);
            end
        end
        ack_result(name);
    endtask

    task automatic test_reset();
        bit ok;
        int w;
        int starts;
        int valids;
        n_tests++;
        if ({data_request, core_start, result_valid, status, core_nonce, result_nonce,
             core_midstate, core_tail} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero required all zero (status %0d)", status);
        end
        lat_lo = 6;
        lat_hi = 6;
        core_auto = 1'b1;
        started.delete();
        digests = {256'h0};
        send_cmd(8'd3, {184'b0, 32'd2, 8'd0, 32'd5}, ok, w);
        n_tests++;
        if (status !== 3'd1 || core_nonce !== 32'd5) begin
            n_fail++;
            $display("FAIL reset_prerun: got status %0d nonce %h required 1/5", status, core_nonce);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({data_request, core_start, result_valid, status, core_nonce, result_nonce} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got status %0d nonce %h required 0", status, core_nonce);
        end
        @(negedge clk);
        rst = 1'b1;
        starts = 0;
        valids = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            starts += int'(core_start);
            valids += int'(result_valid);
        end
        n_tests++;
        if (starts != 0 || valids != 0 || status !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_done_ignored: got starts %0d valids %0d status %0d required 0",
                     starts, valids, status);
        end
        lat_lo = 1;
        lat_hi = 4;
    endtask

    task automatic test_load_mid();
        int pulses;
        cmd_code = 8'd1;
        cmd_payload = {32{8'hA5}};
        cmd_ready = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(data_request);
        end
        n_tests++;
        if (pulses != 1 || core_midstate !== {32{8'hA5}}) begin
            n_fail++;
            $display("FAIL load_mid_first: got pulses %0d mid %h required 1/A5..", pulses,
                     core_midstate);
        end
        cmd_payload = {32{8'h5A}};
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(data_request);
        end
        n_tests++;
        if (pulses != 0 || core_midstate !== {32{8'hA5}}) begin
            n_fail++;
            $display("FAIL load_mid_held: got pulses %0d mid %h required 0/A5..", pulses,
                     core_midstate);
        end
        cmd_ready = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(data_request);
        end
        cmd_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pulses != 1 || core_midstate !== {32{8'h5A}}) begin
            n_fail++;
            $display("FAIL load_mid_second: got pulses %0d mid %h required 1/5A..", pulses,
                     core_midstate);
        end
    endtask

    task automatic test_found();
        plan.delete();
        plan.push_back({8'hFF, rand256() >> 8});
        plan.push_back({8'hFF, rand256() >> 8});
        plan.push_back({8'h00, rand256() >> 8});
        plan.push_back({8'hFF, rand256() >> 8});
        run_job("found", 32'h10, 8'd8, 32'd4);
    endtask

    task automatic test_wrap();
        plan.delete();
        repeat (3) plan.push_back(rand256() | {1'b1, 255'b0});
        run_job("wrap", 32'hFFFF_FFFE, 8'd255, 32'd3);
    endtask

    task automatic test_abort();
        bit ok;
        int w;
        lat_lo = 8;
        lat_hi = 8;
        started.delete();
        digests = {256'h0};
        exp_status = 3'd4;
        send_cmd(8'd3, {184'b0, 32'd5, 8'd8, 32'h20}, ok, w);
        send_cmd(8'd4, rand256(), ok, w);
        n_tests++;
        if (!ok || w > 2) begin
            n_fail++;
            $display("FAIL abort_ack: got ok %b after %0d cycles required ok within 2", ok, w);
        end
        wait_result(ok);
        repeat (10) @(negedge clk);
        n_tests++;
        if (!ok || status !== 3'd4 || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_result: got status %0d valid %b required 4/1", status,
                     result_valid);
        end
        n_tests++;
        if (started.size() != 1) begin
            n_fail++;
            $display("FAIL abort_starts: got %0d required 1", started.size());
        end
        ack_result("abort");
        lat_lo = 1;
        lat_hi = 4;
    endtask

    task automatic test_count_zero_badcmd();
        bit ok;
        int w;
        plan.delete();
        run_job("count_zero", 32'h77, 8'($urandom_range(0, 255)), 32'd0);
        send_cmd(8'h09, rand256(), ok, w);
        n_tests++;
        if (!ok || status !== 3'd5) begin
            n_fail++;
            $display("FAIL bad_cmd: got ok %b status %0d required 1/5", ok, status);
        end
    endtask

    task automatic test_random_jobs();
        bit ok;
        int w;
        logic [255:0] mid;
        logic [255:0] tl;
        logic [31:0] n0;
        logic [31:0] cnt;
        logic [7:0] tgt;
        for (int j = 0; j < 8; j++) begin
            mid = rand256();
            tl = rand256();
            send_cmd(8'd1, mid, ok, w);
            send_cmd(8'd2, tl, ok, w);
            n_tests++;
            if (core_midstate !== mid || core_tail !== tl[95:0]) begin
                n_fail++;
                $display("FAIL rand_load[%0d]: got mid %h tail %h", j, core_midstate, core_tail);
            end
            n0 = (j % 2 == 0) ? 32'($urandom) : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            cnt = 32'($urandom_range(1, 6));
            tgt = 8'($urandom_range(0, 10));
            plan.delete();
            for (int i = 0; i < int'(cnt); i++) plan.push_back(rand256() >> $urandom_range(0, 12));
            run_job("random", n0, tgt, cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        cmd_ready = 1'b0;
        cmd_code = '0;
        cmd_payload = '0;
        result_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_mid();
        test_found();
        test_wrap();
        test_abort();
        test_count_zero_badcmd();
        test_random_jobs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
